// File: rtl/debug_snapshot_tx.sv
// debug_snapshot_tx
// Captures one channel's debug word when a dump is requested and sends it to a
// byte-wide UART transmitter, least significant byte first. After the data bytes
// an optional ready terminator is sent. The capture is a private snapshot, so the
// channel inputs may change freely while the dump is in flight.
// An out-of-range channel select produces a terminator-only dump. It is flagged
// with o_err in the same cycle as o_done.
module debug_snapshot_tx #(
    parameter int          NUM_CH    = 4,
    parameter int          DATA_W    = 136,
    parameter int          LEN_W     = $clog2(DATA_W/8 + 1),
    parameter logic [7:0]  TERM_BYTE = 8'h52,
    parameter bit          TERM_EN   = 1'b1
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst_n,
    input  logic                                                i_req,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]      i_ch_sel,
    input  logic [NUM_CH*DATA_W-1:0]                            i_ch_data,
    input  logic [NUM_CH*LEN_W-1:0]                             i_ch_len,
    output logic [7:0]                                          o_tx_data,
    output logic                                                o_tx_start,
    input  logic                                                i_tx_done,
    output logic                                                o_busy,
    output logic                                                o_done,
    output logic                                                o_err
);

    localparam int NB    = DATA_W / 8;
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT      = 3'd2,
        S_TERM      = 3'd3,
        S_TERM_WAIT = 3'd4,
        S_FIN       = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   snap_q, snap_d;
    logic                err_q, err_d;

    logic                sel_ok;
    logic [DATA_W-1:0]   cap_data;
    logic [LEN_W-1:0]    cap_len_raw;
    logic [LEN_W-1:0]    cap_len;
    logic [LEN_W-1:0]    idx_inc;
    logic [7:0]          cur_byte;

    // Select the requested channel and clamp its byte count to the word size.
    always_comb begin
        sel_ok      = 1'b0;
        cap_data    = '0;
        cap_len_raw = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_ch_sel == SEL_W'(k)) begin
                sel_ok      = 1'b1;
                cap_data    = i_ch_data[k*DATA_W +: DATA_W];
                cap_len_raw = i_ch_len[k*LEN_W +: LEN_W];
            end
        end
        // A missing channel dumps nothing but the terminator.
        if (!sel_ok) begin
            cap_len = '0;
        end else if (cap_len_raw > LEN_W'(NB)) begin
            cap_len = LEN_W'(NB);
        end else begin
            cap_len = cap_len_raw;
        end
    end

    // Pick the snapshot byte addressed by the current index, LSB first.
    always_comb begin
        cur_byte = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (idx_q == LEN_W'(b)) begin
                cur_byte = snap_q[b*8 +: 8];
            end
        end
    end

    // State, byte index and snapshot registers; reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            snap_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            snap_q  <= snap_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: capture on request, then step through the bytes and terminator.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        snap_d  = snap_q;
        err_d   = err_q;
        idx_inc = idx_q + LEN_W'(1);
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    snap_d = cap_data;
                    len_d  = cap_len;
                    err_d  = !sel_ok;
                    idx_d  = '0;
                    if (cap_len == '0) begin
                        state_d = TERM_EN ? S_TERM : S_FIN;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    idx_d = idx_inc;
                    if (idx_inc < len_q) begin
                        state_d = S_SEND;
                    end else begin
                        state_d = TERM_EN ? S_TERM : S_FIN;
                    end
                end
            end
            S_TERM: begin
                state_d = S_TERM_WAIT;
            end
            S_TERM_WAIT: begin
                if (i_tx_done) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state only, so reset forces them low immediately.
    always_comb begin
        o_tx_data  = 8'h00;
        o_tx_start = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        case (state_q)
            S_SEND: begin
                o_tx_start = 1'b1;
                o_tx_data  = cur_byte;
                o_busy     = 1'b1;
            end
            S_WAIT: begin
                o_tx_data  = cur_byte;
                o_busy     = 1'b1;
            end
            S_TERM: begin
                o_tx_start = 1'b1;
                o_tx_data  = TERM_BYTE;
                o_busy     = 1'b1;
            end
            S_TERM_WAIT: begin
                o_tx_data  = TERM_BYTE;
                o_busy     = 1'b1;
            end
            S_FIN: begin
                o_done     = 1'b1;
                o_err      = err_q;
            end
            default: begin
                o_tx_data  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_snapshot_tx.sv
// Directed bench for debug_snapshot_tx.
// u0: 4 x 32-bit channels with terminator. u1: 5 x 136-bit channels with terminator.
// u2: 4 x 32-bit channels without terminator. Each instance has a transmitter model
// that answers every start with a done pulse 10 cycles later.
module tb_debug_snapshot_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req       [3];
    logic        spur      [3];
    logic        resp_done [3] = '{1'b0, 1'b0, 1'b0};
    logic        txdone    [3];
    logic [7:0]  txd       [3];
    logic        txs       [3];
    logic        busy      [3];
    logic        done      [3];
    logic        err       [3];

    logic [1:0]   sel0, sel2;
    logic [2:0]   sel1;
    logic [127:0] data0, data2;
    logic [679:0] data1;
    logic [11:0]  len0, len2;
    logic [24:0]  len1;

    debug_snapshot_tx #(.NUM_CH(4), .DATA_W(32)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_ch_sel(sel0),
        .i_ch_data(data0), .i_ch_len(len0), .o_tx_data(txd[0]), .o_tx_start(txs[0]),
        .i_tx_done(txdone[0]), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]));

    debug_snapshot_tx #(.NUM_CH(5), .DATA_W(136)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_ch_sel(sel1),
        .i_ch_data(data1), .i_ch_len(len1), .o_tx_data(txd[1]), .o_tx_start(txs[1]),
        .i_tx_done(txdone[1]), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]));

    debug_snapshot_tx #(.NUM_CH(4), .DATA_W(32), .TERM_EN(1'b0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[2]), .i_ch_sel(sel2),
        .i_ch_data(data2), .i_ch_len(len2), .o_tx_data(txd[2]), .o_tx_start(txs[2]),
        .i_tx_done(txdone[2]), .o_busy(busy[2]), .o_done(done[2]), .o_err(err[2]));

    always_comb begin
        for (int i = 0; i < 3; i++) txdone[i] = resp_done[i] | spur[i];
    end

    // Transmitter model and activity log, evaluated on the falling edge.
    logic [7:0] log_b [3][256];
    int         log_c [3][256];
    int         nlog      [3] = '{0, 0, 0};
    int         ndone     [3] = '{0, 0, 0};
    int         done_cyc  [3] = '{0, 0, 0};
    logic       done_err  [3] = '{1'b0, 1'b0, 1'b0};
    logic       done_busy [3] = '{1'b0, 1'b0, 1'b0};
    int         cnt       [3] = '{0, 0, 0};
    logic [7:0] cur       [3] = '{8'h00, 8'h00, 8'h00};
    int         stab_bad = 0;
    int         lone_err = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                cnt[i]       = 0;
                resp_done[i] = 1'b0;
            end else begin
                resp_done[i] = 1'b0;
                if (cnt[i] > 0) begin
                    if (txd[i] !== cur[i]) stab_bad++;
                    cnt[i]--;
                    if (cnt[i] == 0) resp_done[i] = 1'b1;
                end
                if (txs[i] === 1'b1) begin
                    if (nlog[i] < 256) begin
                        log_b[i][nlog[i]] = txd[i];
                        log_c[i][nlog[i]] = cyc;
                    end
                    nlog[i]++;
                    cur[i] = txd[i];
                    cnt[i] = 10;
                end
                if (done[i] === 1'b1) begin
                    ndone[i]++;
                    done_cyc[i]  = cyc;
                    done_err[i]  = err[i];
                    done_busy[i] = busy[i];
                end
                if (err[i] === 1'b1 && done[i] !== 1'b1) lone_err++;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_starts(input int i, input int n, input int budget);
        int k = 0;
        while (nlog[i] < n && k < budget) begin
            step(1);
            k++;
        end
        if (nlog[i] < n) begin
            total++;
            bad++;
            $error("FAIL timeout_starts_u%0d observed=%0d expected=%0d", i, nlog[i], n);
        end
    endtask

    task automatic wait_done(input int i, input int n, input int budget);
        int k = 0;
        while (ndone[i] < n && k < budget) begin
            step(1);
            k++;
        end
        if (ndone[i] < n) begin
            total++;
            bad++;
            $error("FAIL timeout_done_u%0d observed=%0d expected=%0d", i, ndone[i], n);
        end
    endtask

    // One-cycle request; a is the cycle whose closing edge accepts it.
    task automatic req_pulse(input int i, output int a);
        req[i] = 1'b1;
        a = cyc;
        step(1);
        req[i] = 1'b0;
    endtask

    logic [7:0] e1 [5];
    logic [7:0] e2 [5];
    logic [7:0] e3 [4];

    initial begin
        int a, b, dn, d1;
        e1 = '{8'h01, 8'h00, 8'h01, 8'h3C, 8'h52};
        e2 = '{8'hD8, 8'hC7, 8'hB6, 8'hA5, 8'h52};
        e3 = '{8'h77, 8'h52, 8'h77, 8'h52};
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i]  = 1'b0;
            spur[i] = 1'b0;
        end
        sel0 = '0; sel1 = '0; sel2 = '0;
        data0 = '0; data1 = '0; data2 = '0;
        len0 = '0; len1 = '0; len2 = '0;
        #1;
        chk("reset_txd",   txd[0],  0);
        chk("reset_start", txs[0],  0);
        chk("reset_busy",  busy[0], 0);
        chk("reset_done",  done[0], 0);
        chk("reset_err",   err[0],  0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // Four-byte dump of channel 1 with terminator.
        data0[32 +: 32] = 32'h3C010001;
        len0[3 +: 3]    = 3'd4;
        sel0            = 2'd1;
        b  = nlog[0];
        dn = ndone[0];
        req_pulse(0, a);
        wait_starts(0, b + 5, 80);
        wait_done(0, dn + 1, 30);
        step(5);
        chk("t1_count", nlog[0] - b, 5);
        for (int k = 0; k < 5; k++) chk($sformatf("t1_byte%0d", k), log_b[0][b+k], e1[k]);
        chk("t1_first_start", log_c[0][b], a + 1);
        for (int k = 1; k < 5; k++) chk($sformatf("t1_gap%0d", k), log_c[0][b+k] - log_c[0][b+k-1], 11);
        chk("t1_ndone", ndone[0] - dn, 1);
        chk("t1_done_cycle", done_cyc[0], log_c[0][b+4] + 11);
        chk("t1_err", done_err[0], 0);
        chk("t1_busy_at_done", done_busy[0], 0);

        // Zero-length channel: terminator only.
        data0[0 +: 32] = 32'hFFFFFFFF;
        len0[0 +: 3]   = 3'd0;
        sel0           = 2'd0;
        b  = nlog[0];
        dn = ndone[0];
        req_pulse(0, a);
        wait_done(0, dn + 1, 40);
        step(3);
        chk("len0_count", nlog[0] - b, 1);
        chk("len0_byte", log_b[0][b], 8'h52);
        chk("len0_start", log_c[0][b], a + 1);
        chk("len0_done_cycle", done_cyc[0], log_c[0][b] + 11);

        // Zero-length without terminator: no starts, done right after acceptance.
        sel2 = 2'd0;
        len2 = '0;
        b  = nlog[2];
        dn = ndone[2];
        req_pulse(2, a);
        wait_done(2, dn + 1, 10);
        step(3);
        chk("noterm_starts", nlog[2] - b, 0);
        chk("noterm_ndone", ndone[2] - dn, 1);
        chk("noterm_done_cycle", done_cyc[2], a + 1);
        chk("noterm_err", done_err[2], 0);

        // Full 17-byte word, inputs scrambled right after acceptance.
        sel1 = 3'd2;
        for (int k = 0; k < 17; k++) data1[2*136 + k*8 +: 8] = 8'(16 + k);
        len1[10 +: 5] = 5'd17;
        b  = nlog[1];
        dn = ndone[1];
        req_pulse(1, a);
        data1 = ~data1;
        len1[10 +: 5] = 5'd2;
        wait_starts(1, b + 18, 250);
        wait_done(1, dn + 1, 30);
        step(2);
        chk("wide_count", nlog[1] - b, 18);
        for (int k = 0; k < 17; k++) chk($sformatf("wide_byte%0d", k), log_b[1][b+k], 16 + k);
        chk("wide_term", log_b[1][b+17], 8'h52);
        chk("wide_err", done_err[1], 0);

        // Byte count above the word size is clamped.
        for (int k = 0; k < 17; k++) data1[2*136 + k*8 +: 8] = 8'(16 + k);
        len1[10 +: 5] = 5'd20;
        b  = nlog[1];
        dn = ndone[1];
        req_pulse(1, a);
        wait_starts(1, b + 18, 250);
        wait_done(1, dn + 1, 30);
        step(15);
        chk("clamp_count", nlog[1] - b, 18);
        chk("clamp_last_data", log_b[1][b+16], 8'h20);
        chk("clamp_term", log_b[1][b+17], 8'h52);

        // Nonexistent channel.
        sel1 = 3'd5;
        b  = nlog[1];
        dn = ndone[1];
        req_pulse(1, a);
        wait_done(1, dn + 1, 40);
        step(3);
        chk("badch_count", nlog[1] - b, 1);
        chk("badch_byte", log_b[1][b], 8'h52);
        chk("badch_ndone", ndone[1] - dn, 1);
        chk("badch_err_with_done", done_err[1], 1);
        chk("badch_busy_at_done", done_busy[1], 0);

        // Reset in the middle of a dump.
        data0[32 +: 32] = 32'hA5B6C7D8;
        len0[3 +: 3]    = 3'd4;
        sel0            = 2'd1;
        b = nlog[0];
        req_pulse(0, a);
        wait_starts(0, b + 2, 40);
        step(3);
        chk("pre_reset_txd", txd[0], 8'hC7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_txd",   txd[0],  0);
        chk("midrst_start", txs[0],  0);
        chk("midrst_busy",  busy[0], 0);
        chk("midrst_done",  done[0], 0);
        chk("midrst_err",   err[0],  0);
        step(3);
        rst_n = 1'b1;
        step(25);
        chk("midrst_no_more_starts", nlog[0] - b, 2);
        chk("midrst_idle_busy", busy[0], 0);

        // Request present at the first edge after reset release.
        b  = nlog[0];
        dn = ndone[0];
        rst_n = 1'b0;
        step(1);
        rst_n  = 1'b1;
        req[0] = 1'b1;
        a = cyc;
        step(1);
        req[0] = 1'b0;
        wait_starts(0, b + 5, 80);
        wait_done(0, dn + 1, 30);
        chk("postrst_first_start", log_c[0][b], a + 1);
        for (int k = 0; k < 5; k++) chk($sformatf("postrst_byte%0d", k), log_b[0][b+k], e2[k]);

        // Spurious done pulses while idle, then a continuously held request.
        data0[96 +: 32] = 32'h00000077;
        len0[9 +: 3]    = 3'd1;
        sel0            = 2'd3;
        b  = nlog[0];
        dn = ndone[0];
        repeat (3) begin
            spur[0] = 1'b1;
            step(1);
            spur[0] = 1'b0;
            step(1);
        end
        chk("spur_idle_starts", nlog[0] - b, 0);
        chk("spur_idle_busy", busy[0], 0);
        req[0] = 1'b1;
        a = cyc;
        wait_done(0, dn + 1, 60);
        d1 = done_cyc[0];
        step(1);
        spur[0] = 1'b1;
        step(1);
        spur[0] = 1'b0;
        wait_done(0, dn + 2, 60);
        req[0] = 1'b0;
        step(20);
        chk("held_count", nlog[0] - b, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("held_byte%0d", k), log_b[0][b+k], e3[k]);
        chk("held_ndone", ndone[0] - dn, 2);
        chk("held_first_start", log_c[0][b], a + 1);
        chk("held_restart_gap", log_c[0][b+2], d1 + 2);

        chk("tx_data_stable", stab_bad, 0);
        chk("err_without_done", lone_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
